// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, single-cycle-latency imem requests, prefetch
// queue and a valid/ready IF/ID handshake with redirect flush.
module fetch_queue_unit #(
    parameter int               ISIZE    = 32,
    parameter int               ASIZE    = 16,
    parameter int               DEPTH    = 4,
    parameter int               PC_STEP  = 1,
    parameter logic [ASIZE-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [ASIZE-1:0]           imem_addr,
    input  logic [ISIZE-1:0]           imem_rdata,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [ISIZE-1:0]           id_inst,
    output logic [ASIZE-1:0]           id_pc,
    input  logic                       redirect_valid,
    input  logic [ASIZE-1:0]           redirect_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int LW = PW + 2;

    logic [ASIZE-1:0] pc;
    logic [ASIZE-1:0] tag;
    logic             inflight;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [OW-1:0]    occ;
    logic [ISIZE-1:0] q_inst [DEPTH];
    logic [ASIZE-1:0] q_pc   [DEPTH];
    logic             pop;
    logic             push;
    logic [LW-1:0]    level;

    assign id_valid  = rst && (occ != '0);
    assign pop       = id_valid && id_ready;
    // A response is only kept if nothing flushed the queue in the cycle it lands.
    assign push      = rst && inflight && !redirect_valid;
    // Projected fill counts the word already in flight and the entry leaving now.
    assign level     = LW'(occ) + LW'(inflight) - LW'(pop);
    assign imem_req  = rst && (level < LW'(DEPTH));
    assign imem_addr = pc;
    assign id_inst   = id_valid ? q_inst[rd_ptr] : '0;
    assign id_pc     = id_valid ? q_pc[rd_ptr]   : '0;
    assign occupancy = rst ? occ : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC;
            tag      <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc  <= pc + ASIZE'(PC_STEP);
                tag <= pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= tag;
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && occ == OW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus a randomized run checked
// against an in-order expected-PC stream model.
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst;
    logic        id_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic [31:0] rdata0, rdata1;
    logic        valid0, valid1;
    logic [31:0] inst0, inst1;
    logic [15:0] pc0, pc1;
    logic [2:0]  occ0, occ1;

    int          errors;
    int          checks;
    logic [15:0] exp_pc;

    fetch_queue_unit #(.RESET_PC(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
        .id_ready(id_ready), .id_valid(valid0), .id_inst(inst0), .id_pc(pc0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .occupancy(occ0)
    );

    fetch_queue_unit #(.RESET_PC(16'hFFFE)) dut1 (
        .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .id_ready(id_ready), .id_valid(valid1), .id_inst(inst1), .id_pc(pc1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .occupancy(occ1)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'h0000_1000 + {16'h0000, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories; garbage when no request so stray captures show up.
    always @(posedge clk) rdata0 <= req0 ? mem_word(addr0) : 32'hDEAD_BEEF;
    always @(posedge clk) rdata1 <= req1 ? mem_word(addr1) : 32'hDEAD_BEEF;

    task automatic test_reset();
        rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req0); end
            checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid0); end
            checks++; if (occ0 !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ0); end
            checks++; if (inst0 !== 32'h0 || pc0 !== 16'h0) begin errors++; $display("FAIL reset_head: got inst=%h pc=%h want 0", inst0, pc0); end
        end
    endtask

    task automatic test_stream();
        exp_pc = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = 1'b1; id_ready = 1'b1;
            #1;
            checks++; if (req0 !== 1'b1 || addr0 !== 16'(i)) begin errors++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", i, req0, addr0, 16'(i)); end
            if (i < 2) begin
                checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL stream_early_valid[%0d]: got %b want 0", i, valid0); end
            end else begin
                checks++; if (valid0 !== 1'b1 || pc0 !== exp_pc || inst0 !== mem_word(exp_pc)) begin errors++; $display("FAIL stream_head[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i, valid0, pc0, inst0, exp_pc, mem_word(exp_pc)); end
                exp_pc++;
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            id_ready = 1'b0;
            #1;
            checks++; if (valid0 !== 1'b1 || pc0 !== exp_pc || inst0 !== mem_word(exp_pc)) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h want pc=%h", k, valid0, pc0, inst0, exp_pc); end
            if (k >= 3) begin
                checks++; if (occ0 !== 3'd4 || req0 !== 1'b0) begin errors++; $display("FAIL stall_full[%0d]: got occ=%0d req=%b want occ=4 req=0", k, occ0, req0); end
            end
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            id_ready = 1'b1;
            #1;
            checks++; if (valid0 !== 1'b1 || pc0 !== exp_pc || inst0 !== mem_word(exp_pc)) begin errors++; $display("FAIL stall_resume[%0d]: got v=%b pc=%h inst=%h want pc=%h", k, valid0, pc0, inst0, exp_pc); end
            exp_pc++;
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (valid0 !== 1'b0 || req0 !== 1'b1 || addr0 !== 16'h0040) begin errors++; $display("FAIL redir_r1: got v=%b req=%b addr=%h want v=0 req=1 addr=0040", valid0, req0, addr0); end
        @(negedge clk); #1;
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL redir_r2: got v=%b want 0", valid0); end
        @(negedge clk); #1;
        checks++; if (valid0 !== 1'b1 || pc0 !== 16'h0040 || inst0 !== 32'h0000_1040) begin errors++; $display("FAIL redir_r3: got v=%b pc=%h inst=%h want pc=0040 inst=00001040", valid0, pc0, inst0); end
        exp_pc = 16'h0041;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checks++; if (valid0 !== 1'b1 || pc0 !== exp_pc || inst0 !== mem_word(exp_pc)) begin errors++; $display("FAIL redir_stream[%0d]: got v=%b pc=%h inst=%h want pc=%h", k, valid0, pc0, inst0, exp_pc); end
            exp_pc++;
        end
    endtask

    task automatic test_redirect_stalled();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            id_ready = 1'b0;
        end
        #1;
        checks++; if (occ0 !== 3'd4) begin errors++; $display("FAIL rs_fill: got occ=%0d want 4", occ0); end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 16'h0080;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (occ0 !== 3'd0 || valid0 !== 1'b0) begin errors++; $display("FAIL rs_flush: got occ=%0d v=%b want occ=0 v=0", occ0, valid0); end
        for (int k = 0; k < 6; k++) @(negedge clk);
        exp_pc = 16'h0080;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            id_ready = 1'b1;
            #1;
            checks++; if (valid0 !== 1'b1 || pc0 !== exp_pc || inst0 !== mem_word(exp_pc)) begin errors++; $display("FAIL rs_stream[%0d]: got v=%b pc=%h inst=%h want pc=%h", k, valid0, pc0, inst0, exp_pc); end
            exp_pc++;
        end
    endtask

    task automatic test_pc_wrap();
        logic [15:0] e;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst = 1'b0; id_ready = 1'b1;
        end
        #1;
        checks++; if (req1 !== 1'b0 || valid1 !== 1'b0 || occ1 !== 3'd0) begin errors++; $display("FAIL wrap_reset: got req=%b v=%b occ=%0d want 0", req1, valid1, occ1); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            if (i < 4) begin
                e = 16'hFFFE + 16'(i);
                checks++; if (req1 !== 1'b1 || addr1 !== e) begin errors++; $display("FAIL wrap_addr[%0d]: got req=%b addr=%h want addr=%h", i, req1, addr1, e); end
            end
            if (i >= 2) begin
                e = 16'hFFFE + 16'(i - 2);
                checks++; if (valid1 !== 1'b1 || pc1 !== e || inst1 !== mem_word(e)) begin errors++; $display("FAIL wrap_head[%0d]: got v=%b pc=%h inst=%h want pc=%h", i, valid1, pc1, inst1, e); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            id_ready = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req0 !== 1'b0 || valid0 !== 1'b0 || occ0 !== 3'd0 || inst0 !== 32'h0 || pc0 !== 16'h0) begin errors++; $display("FAIL midrst_zero: got req=%b v=%b occ=%0d inst=%h pc=%h want all 0", req0, valid0, occ0, inst0, pc0); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (valid0 !== 1'b0 || req0 !== 1'b1 || addr0 !== 16'h0000) begin errors++; $display("FAIL midrst_refetch: got v=%b req=%b addr=%h want v=0 req=1 addr=0000", valid0, req0, addr0); end
        @(negedge clk); #1;
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL midrst_stale: got v=%b inst=%h want v=0", valid0, inst0); end
        exp_pc = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checks++; if (valid0 !== 1'b1 || pc0 !== exp_pc || inst0 !== mem_word(exp_pc)) begin errors++; $display("FAIL midrst_stream[%0d]: got v=%b pc=%h inst=%h want pc=%h", k, valid0, pc0, inst0, exp_pc); end
            exp_pc++;
        end
    endtask

    task automatic test_random();
        int          since;
        int          cool;
        logic [15:0] rpc;
        since = 100; cool = 0; rpc = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            id_ready = ($urandom_range(0, 3) != 0);
            if (cool == 0 && $urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                rpc = 16'($urandom);
                redirect_pc = rpc;
                since = 0;
                cool = 4;
            end else begin
                redirect_valid = 1'b0;
                if (since < 100) since++;
                if (cool > 0) cool--;
            end
            #1;
            checks++; if (occ0 > 3'd4 || valid0 !== (occ0 != 3'd0)) begin errors++; $display("FAIL rnd_occ[%0d]: got occ=%0d v=%b", i, occ0, valid0); end
            if (since == 1) begin
                checks++; if (valid0 !== 1'b0 || req0 !== 1'b1 || addr0 !== rpc) begin errors++; $display("FAIL rnd_redir1[%0d]: got v=%b req=%b addr=%h want addr=%h", i, valid0, req0, addr0, rpc); end
            end
            if (since == 3) begin
                checks++; if (valid0 !== 1'b1 || pc0 !== rpc) begin errors++; $display("FAIL rnd_redir3[%0d]: got v=%b pc=%h want pc=%h", i, valid0, pc0, rpc); end
            end
            if (redirect_valid) begin
                exp_pc = rpc;
            end else if (valid0 && id_ready) begin
                checks++; if (pc0 !== exp_pc || inst0 !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_pop[%0d]: got pc=%h inst=%h want pc=%h inst=%h", i, pc0, inst0, exp_pc, mem_word(exp_pc)); end
                exp_pc++;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_pc = '0;
        rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stalled();
        test_pc_wrap();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
